retire_free_list: RTL and testbench

- Consumer end of the ROB commit interface.
- Keeps the retirement (architectural) rename map, arch_rd -> phys_rd. Each commit installs the new mapping and frees the physical register it replaces.
- Freed registers go into a circular free-list FIFO. The rename/dispatch stage pops DISPATCH_WIDTH physical registers per cycle from it.
- Sits between the ROB commit port and the rename stage.

---
 rtl/retire_free_list_pkg.sv | 19 +
 rtl/retire_free_list_free_list_fifo.sv | 75 +++++++
 rtl/retire_free_list.sv | 59 +++++
 tb/tb_retire_free_list.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/retire_free_list_pkg.sv
// Shared sizing and commit-lane type for the retirement map / free-list block.
package retire_free_list_pkg;
    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS            = 64;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int ARCH_REGS            = 32;
    localparam int ARCH_ADDR_WIDTH      = 5;
    localparam int FREE_REGS            = PHYS_REGS - ARCH_REGS;

    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_t;
    typedef logic [ARCH_ADDR_WIDTH-1:0]      arch_t;
    typedef logic [PHYS_REGS_ADDR_WIDTH:0]   count_t;

    typedef struct packed {
        logic  en;
        phys_t phys_rd;
        arch_t arch_rd;
    } commit_lane_t;
endpackage

// File: rtl/retire_free_list_free_list_fifo.sv
// Multi-push / multi-pop circular free list; lanes are compacted so set
// request bits map onto consecutive slots starting at head (pop) or tail (push).
module free_list_fifo
    import retire_free_list_pkg::*;
(
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DISPATCH_WIDTH-1:0]                           push_en,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] push_data,
    input  logic [DISPATCH_WIDTH-1:0]                           pop_req,
    output logic                                                ready,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] pop_data,
    output logic [PHYS_REGS_ADDR_WIDTH:0]                       count
);
    phys_t  mem [PHYS_REGS];
    phys_t  head, tail, head_next, tail_next, pop_ptr, push_ptr;
    phys_t  push_slot [DISPATCH_WIDTH];
    count_t n_pop, n_push, count_next;

    assign ready = (count >= count_t'(DISPATCH_WIDTH));

    // NOTE: pop_ptr/push_ptr are blocking running offsets, so each lane sees the sum of earlier lanes.
    always_comb begin
        pop_ptr = head;
        n_pop   = '0;
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            pop_data[w] = mem[pop_ptr];
            if (pop_req[w]) begin
                pop_ptr = pop_ptr + phys_t'(1);
                n_pop   = n_pop + count_t'(1);
            end
        end
        if (!ready) begin
            pop_ptr = head;
            n_pop   = '0;
        end
        head_next = pop_ptr;
    end

    always_comb begin
        push_ptr = tail;
        n_push   = '0;
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            push_slot[w] = push_ptr;
            if (push_en[w]) begin
                push_ptr = push_ptr + phys_t'(1);
                n_push   = n_push + count_t'(1);
            end
        end
        tail_next = push_ptr;
    end

    assign count_next = count + n_push - n_pop;

    // NOTE: the storage is reset because its initial contents (the free registers) are architecturally visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= phys_t'(FREE_REGS);
            count <= count_t'(FREE_REGS);
            for (int i = 0; i < PHYS_REGS; i++)
                mem[i] <= (i < FREE_REGS) ? phys_t'(i + ARCH_REGS) : '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            for (int w = 0; w < DISPATCH_WIDTH; w++)
                if (push_en[w]) mem[push_slot[w]] <= push_data[w];
        end
    end

    // Occupancy can never legally exceed the non-architectural registers or go negative.
    free_count_bounds: assert property (@(posedge clk) disable iff (!rst)
        ((count + n_push) >= n_pop) && (count_next <= count_t'(FREE_REGS)));
endmodule

// File: rtl/retire_free_list.sv
// Retirement rename map fed by ROB commits; displaced mappings are recycled
// through the free-list FIFO to the rename stage.
module retire_free_list
    import retire_free_list_pkg::*;
(
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DISPATCH_WIDTH-1:0]                           commit_en,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd,
    input  logic [DISPATCH_WIDTH-1:0][4:0]                      commit_arch_rd,
    input  logic [DISPATCH_WIDTH-1:0]                           alloc_req,
    output logic                                                alloc_ready,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] alloc_phys_rd,
    output logic [PHYS_REGS_ADDR_WIDTH:0]                       free_count,
    input  logic [4:0]                                          dbg_arch_addr,
    output logic [PHYS_REGS_ADDR_WIDTH-1:0]                     dbg_phys
);
    commit_lane_t [DISPATCH_WIDTH-1:0]                    lane;
    phys_t                                                rrat      [ARCH_REGS];
    phys_t                                                rrat_next [ARCH_REGS];
    logic [DISPATCH_WIDTH-1:0]                            push_en;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  push_data;

    // Lanes walk a working copy of the map so a later lane frees an earlier lane's mapping.
    always_comb begin
        rrat_next = rrat;
        push_en   = '0;
        push_data = '0;
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            lane[w] = '{en: commit_en[w], phys_rd: commit_phys_rd[w], arch_rd: commit_arch_rd[w]};
            if (lane[w].en && (lane[w].arch_rd != '0)) begin
                push_en[w]                   = 1'b1;
                push_data[w]                 = rrat_next[lane[w].arch_rd];
                rrat_next[lane[w].arch_rd]   = lane[w].phys_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) rrat[i] <= phys_t'(i);
        end else begin
            rrat <= rrat_next;
        end
    end

    assign dbg_phys = rrat[dbg_arch_addr];

    free_list_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_en   (push_en),
        .push_data (push_data),
        .pop_req   (alloc_req),
        .ready     (alloc_ready),
        .pop_data  (alloc_phys_rd),
        .count     (free_count)
    );
endmodule

// File: tb/tb_retire_free_list.sv
// Directed bench for retire_free_list with a queue model of the free list and
// a held-register scoreboard that rejects duplicate grants.
module tb_retire_free_list;
    logic            clk;
    logic            rst;
    logic [1:0]      commit_en;
    logic [1:0][5:0] commit_phys_rd;
    logic [1:0][4:0] commit_arch_rd;
    logic [1:0]      alloc_req;
    logic            alloc_ready;
    logic [1:0][5:0] alloc_phys_rd;
    logic [6:0]      free_count;
    logic [4:0]      dbg_arch_addr;
    logic [5:0]      dbg_phys;

    int n_cmp  = 0;
    int n_fail = 0;

    int free_q[$];
    int inflight_q[$];
    int rrat_m[32];
    bit held[64];

    retire_free_list dut (
        .clk            (clk),
        .rst            (rst),
        .commit_en      (commit_en),
        .commit_phys_rd (commit_phys_rd),
        .commit_arch_rd (commit_arch_rd),
        .alloc_req      (alloc_req),
        .alloc_ready    (alloc_ready),
        .alloc_phys_rd  (alloc_phys_rd),
        .free_count     (free_count),
        .dbg_arch_addr  (dbg_arch_addr),
        .dbg_phys       (dbg_phys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        inflight_q.delete();
        for (int i = 32; i < 64; i++) free_q.push_back(i);
        for (int i = 0; i < 32; i++) rrat_m[i] = i;
        for (int i = 0; i < 64; i++) held[i] = (i < 32);
    endtask

    task automatic dbg_check(input int addr, input int exp);
        dbg_arch_addr = 5'(addr);
        #1;
        check("dbg_phys", 32'(dbg_phys), exp);
    endtask

    // One clock of stimulus: checks grants against the model, then commits in lane order.
    task automatic cycle(input logic [1:0] en, input int a0, input int p0,
                         input int a1, input int p1, input logic [1:0] req);
        int  a[2];
        int  p[2];
        int  got[$];
        int  k;
        bit  rdy;
        a[0] = a0; a[1] = a1; p[0] = p0; p[1] = p1;
        commit_en         = en;
        commit_arch_rd[0] = 5'(a0);
        commit_arch_rd[1] = 5'(a1);
        commit_phys_rd[0] = 6'(p0);
        commit_phys_rd[1] = 6'(p1);
        alloc_req         = req;
        #1;
        rdy = (free_q.size() >= 2);
        check("alloc_ready", 32'(alloc_ready), 32'(rdy));
        check("free_count", 32'(free_count), free_q.size());
        k = 0;
        if (rdy) begin
            for (int w = 0; w < 2; w++) begin
                if (req[w]) begin
                    check("grant", 32'(alloc_phys_rd[w]), free_q[k]);
                    got.push_back(int'(alloc_phys_rd[w]));
                    k++;
                end
            end
            foreach (got[i]) begin
                check("no_dup", 32'(held[got[i][5:0]]), 0);
                held[got[i][5:0]] = 1'b1;
                inflight_q.push_back(free_q.pop_front());
            end
        end
        for (int w = 0; w < 2; w++) begin
            if (en[w] && a[w] != 0) begin
                int old;
                old       = rrat_m[a[w]];
                rrat_m[a[w]] = p[w];
                free_q.push_back(old);
                held[old] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        commit_en      = '0;
        commit_phys_rd = '0;
        commit_arch_rd = '0;
        alloc_req      = '0;
        dbg_arch_addr  = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_free_count", 32'(free_count), 32);
        rst = 1'b1;
        #1;
        check("rst_free_count", 32'(free_count), 32);
        check("rst_alloc_ready", 32'(alloc_ready), 1);
        alloc_req = 2'b11;
        #1;
        check("rst_grant0", 32'(alloc_phys_rd[0]), 32);
        check("rst_grant1", 32'(alloc_phys_rd[1]), 33);
        dbg_check(7, 7);

        // Lane 1 alone takes the head entry.
        alloc_req = 2'b10;
        #1;
        check("lane1_only_grant", 32'(alloc_phys_rd[1]), 32);
        cycle(2'b00, 0, 0, 0, 0, 2'b10);
        cycle(2'b00, 0, 0, 0, 0, 2'b11);
        check("after_alloc_free_count", 32'(free_count), 29);

        cycle(2'b01, 5, 32, 0, 0, 2'b00);
        dbg_check(5, 32);
        check("commit_free_count", 32'(free_count), 30);

        // Both lanes hit arch 3: lane 1 frees lane 0's new register.
        cycle(2'b11, 3, 33, 3, 34, 2'b00);
        dbg_check(3, 34);
        check("same_arch_free_count", 32'(free_count), 32);
        inflight_q.delete();

        cycle(2'b01, 0, 50, 7, 60, 2'b00);
        check("x0_free_count", 32'(free_count), 32);
        dbg_check(0, 0);
        dbg_check(7, 7);

        // Drain down to one entry; phys 5 and 3 come out after the initial pool.
        repeat (15) cycle(2'b00, 0, 0, 0, 0, 2'b11);
        cycle(2'b00, 0, 0, 0, 0, 2'b01);
        check("drain_not_ready", 32'(alloc_ready), 0);
        check("drain_free_count", 32'(free_count), 1);
        cycle(2'b00, 0, 0, 0, 0, 2'b11);
        check("stalled_free_count", 32'(free_count), 1);

        // Steady commit + allocate traffic wraps both pointers.
        for (int c = 0; c < 40; c++) begin
            logic [1:0] en;
            logic [1:0] req;
            int p0, p1;
            en = 2'b00; p0 = 0; p1 = 0;
            if (inflight_q.size() >= 2) begin
                en = 2'b11;
                p0 = inflight_q.pop_front();
                p1 = inflight_q.pop_front();
            end
            if (free_q.size() >= 2) req = (c % 5 == 0) ? 2'b10 : 2'b11;
            else req = 2'b00;
            cycle(en, 1 + (c * 3) % 31, p0, 1 + (c * 3 + 7) % 31, p1, req);
        end
        dbg_check(1, rrat_m[1]);
        dbg_check(8, rrat_m[8]);

        // Asynchronous reset mid-stream discards the pending commit and allocation.
        commit_en         = 2'b11;
        commit_arch_rd[0] = 5'd3;
        commit_arch_rd[1] = 5'd5;
        commit_phys_rd[0] = 6'd40;
        commit_phys_rd[1] = 6'd41;
        alloc_req         = 2'b11;
        dbg_arch_addr     = 5'd3;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_free_count", 32'(free_count), 32);
        check("midrst_alloc_ready", 32'(alloc_ready), 1);
        check("midrst_grant0", 32'(alloc_phys_rd[0]), 32);
        check("midrst_grant1", 32'(alloc_phys_rd[1]), 33);
        check("midrst_dbg3", 32'(dbg_phys), 3);
        @(posedge clk);
        #1;
        check("midrst_hold_free_count", 32'(free_count), 32);
        dbg_check(5, 5);
        rst = 1'b1;
        model_reset();
        cycle(2'b00, 0, 0, 0, 0, 2'b11);
        cycle(2'b00, 0, 0, 0, 0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
